axi_vga_slave_regs: RTL and testbench
=====================================

AXI_VGA_SLAVE_REGS -- requirements
Module: axi_vga_slave_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering 4 word registers.
REQ-003 SHALL have port ACLK  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESET  input  1  asynchronous reset, active-high.
REQ-005 SHALL have ports S_AXI_AWADDR input 4, S_AXI_AWPROT input 3, S_AXI_AWVALID input 1, S_AXI_AWREADY output 1  write address channel.
REQ-006 SHALL have ports S_AXI_WDATA input 32, S_AXI_WSTRB input 4, S_AXI_WVALID input 1, S_AXI_WREADY output 1  write data channel.
REQ-007 SHALL have ports S_AXI_BRESP output 2, S_AXI_BVALID output 1, S_AXI_BREADY input 1  write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR input 4, S_AXI_ARPROT input 3, S_AXI_ARVALID input 1, S_AXI_ARREADY output 1  read address channel.
REQ-009 SHALL have ports S_AXI_RDATA output 32, S_AXI_RRESP output 2, S_AXI_RVALID output 1, S_AXI_RREADY input 1  read data channel.
REQ-010 SHALL have port vsync_i  input  1  frame sync, synchronous to ACLK.
REQ-011 SHALL have ports ctrl_o, bg_color_o, fb_base_o, aux_o  output  32 each  active copies of registers 0..3.

Function
REQ-012 Register map: 0x0 CTRL, 0x4 BG_COLOR, 0x8 FB_BASE, 0xC AUX; all 32-bit RW shadow registers; address bits [1:0] ignored.
REQ-013 Write FSM states: W_IDLE, W_RESP; in W_IDLE, AWREADY=1 until AW captured, WREADY=1 until W captured; AW and W accepted independently, in either order or the same cycle.
REQ-014 At the edge after both AW and W are held: shadow register updated byte-wise per WSTRB (strobe 0 keeps byte), BVALID=1, BRESP=2'b00, FSM to W_RESP.
REQ-015 Same-cycle AW+W handshake at edge N -> register updated and BVALID high at edge N+1.
REQ-016 W_RESP: AWREADY=WREADY=0; BVALID held until BREADY sampled high, then W_IDLE next cycle; BVALID never drops without BREADY.
REQ-017 Read FSM states: R_IDLE (ARREADY=1), R_DATA (ARREADY=0); AR handshake at edge N -> RVALID=1, RRESP=2'b00, RDATA at edge N+1.
REQ-018 RDATA SHALL return the shadow value as of AR handshake edge N; a write committing at edge N is not visible to that read.
REQ-019 RDATA/RVALID held stable until RREADY sampled high, then R_IDLE.
REQ-020 Read and write FSMs SHALL be independent and operate concurrently; one outstanding transaction per direction.
REQ-021 AWPROT/ARPROT SHALL be ignored; no SLVERR/DECERR is ever returned.
REQ-022 vsync_i rising edge detected with one registered copy; on detect, all four active outputs load from shadow in one cycle.
REQ-023 CTRL bit 1 (IMMEDIATE) = 1: active outputs SHALL follow shadow every cycle (one-cycle lag), ignoring vsync_i.
REQ-024 Shadow write and vsync edge in the same cycle: active loads the pre-write shadow value; new value transfers at next vsync.

Reset
REQ-025 ARESET asserted: all shadow and active registers 0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, FSMs in idle, vsync edge register 0.
REQ-026 Ready outputs SHALL rise on the first edge after ARESET deasserts.
REQ-027 Reset mid-transaction SHALL abort the transaction with no response issued afterwards.

Structure
REQ-028 Package axi_vga_pkg SHALL hold register offsets, CTRL bit indices, RESP_OKAY, and FSM state enums.
REQ-029 Sub-module axi_vga_strb_merge SHALL implement the byte-strobe merge (old, new, strobe -> result).

Verification
REQ-030 Writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then reads -> RDATA 0x1,0x2,0x3,0x4, all RESP 2'b00.
REQ-031 W before AW by 3 cycles, BREADY held low 5 cycles -> BVALID high throughout, single register update.
REQ-032 BG_COLOR=0xAABBCCDD; write 0x11223344 with WSTRB 4'b0101 -> readback 0xAA22CC44.
REQ-033 FB_BASE=0x1000, no vsync -> fb_base_o=0; one vsync pulse -> fb_base_o=0x1000; CTRL=0x2 -> outputs track within 1 cycle.
REQ-034 ARESET mid-write (after AW, before W) -> all outputs 0, next full write completes normally.

Source files
------------

// File: rtl/axi_vga_pkg.sv
// Shared constants and state types for the VGA register slave.
package axi_vga_pkg;

  // Byte offsets of the four word registers
  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_BG_COLOR = 4'h4;
  localparam logic [3:0] OFF_FB_BASE  = 4'h8;
  localparam logic [3:0] OFF_AUX      = 4'hC;

  // Word indices into the register arrays
  localparam int IDX_CTRL     = 0;
  localparam int IDX_BG_COLOR = 1;
  localparam int IDX_FB_BASE  = 2;
  localparam int IDX_AUX      = 3;

  // CTRL bit: active copies follow the shadow copies every cycle
  localparam int CTRL_IMMEDIATE_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_vga_strb_merge.sv
// Byte-lane merge: each strobe bit selects the new byte, otherwise the old byte is kept.
module axi_vga_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Per-byte select between old and new data
  always_comb begin
    merged = old_data;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_vga_slave_regs.sv
// AXI4-Lite slave with four shadow registers and vsync-latched active copies.
//
// Write FSM
//   state  | meaning
//   W_IDLE | accepting AW and W independently; commits once both are held
//   W_RESP | BVALID asserted, waiting for BREADY
// Read FSM
//   state  | meaning
//   R_IDLE | ARREADY asserted, waiting for an address
//   R_DATA | RVALID asserted with captured data, waiting for RREADY
module axi_vga_slave_regs
  import axi_vga_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            vsync_i,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   bg_color_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   fb_base_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   aux_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic [DW-1:0] shadow [4];
  logic [DW-1:0] active [4];

  w_state_t      w_state;
  logic          awready_q, wready_q, bvalid_q;
  logic          aw_held, w_held;
  logic [1:0]    awidx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [DW-1:0] merged;

  r_state_t      r_state;
  logic          arready_q, rvalid_q;
  logic [DW-1:0] rdata_q;

  logic          vsync_q;
  logic          load_active;

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  axi_vga_strb_merge #(.DATA_WIDTH(DW)) u_merge (
    .old_data (shadow[awidx_q]),
    .new_data (wdata_q),
    .strb     (wstrb_q),
    .merged   (merged)
  );

  // Write channel: capture AW and W separately, commit one cycle after both are held
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            shadow[awidx_q] <= merged;
            bvalid_q        <= 1'b1;
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            awready_q       <= 1'b0;
            wready_q        <= 1'b0;
            w_state         <= W_RESP;
          end else begin
            if (awready_q && S_AXI_AWVALID) begin
              aw_held   <= 1'b1;
              awidx_q   <= S_AXI_AWADDR[3:2];
              awready_q <= 1'b0;
            end else begin
              awready_q <= !aw_held;
            end
            if (wready_q && S_AXI_WVALID) begin
              w_held   <= 1'b1;
              wdata_q  <= S_AXI_WDATA;
              wstrb_q  <= S_AXI_WSTRB;
              wready_q <= 1'b0;
            end else begin
              wready_q <= !w_held;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: sample the shadow value on the AR handshake and hold until RREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arready_q && S_AXI_ARVALID) begin
            rdata_q   <= shadow[S_AXI_ARADDR[3:2]];
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // A same-cycle shadow write is not seen here: the load takes the pre-write value
  assign load_active = (vsync_i && !vsync_q) || shadow[IDX_CTRL][CTRL_IMMEDIATE_BIT];

  // Active copies load from shadow on a vsync rising edge or every cycle in immediate mode
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      vsync_q <= 1'b0;
      for (int i = 0; i < 4; i++) active[i] <= '0;
    end else begin
      vsync_q <= vsync_i;
      if (load_active) begin
        for (int i = 0; i < 4; i++) active[i] <= shadow[i];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign ctrl_o     = active[IDX_CTRL];
  assign bg_color_o = active[IDX_BG_COLOR];
  assign fb_base_o  = active[IDX_FB_BASE];
  assign aux_o      = active[IDX_AUX];

endmodule

// File: tb/tb_axi_vga_slave_regs.sv
// Scoreboard bench for axi_vga_slave_regs with a register-array reference model.
module tb_axi_vga_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        vsync_i;
  logic [31:0] ctrl_o, bg_color_o, fb_base_o, aux_o;

  axi_vga_slave_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .vsync_i(vsync_i),
    .ctrl_o(ctrl_o), .bg_color_o(bg_color_o), .fb_base_o(fb_base_o), .aux_o(aux_o)
  );

  always #5 ACLK = ~ACLK;

  int tests  = 0;
  int errors = 0;

  // Reference model: what software wrote, and what the display side should see
  logic [31:0] model_sh  [4];
  logic [31:0] model_act [4];
  logic [31:0] rq [$];
  logic [1:0]  bq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bound(input string name, input bit ok);
    tests++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: handshake timed out, got none expected one", name);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_active(input string name);
    check({name, "_ctrl"},  ctrl_o,     model_act[0]);
    check({name, "_bg"},    bg_color_o, model_act[1]);
    check({name, "_fb"},    fb_base_o,  model_act[2]);
    check({name, "_aux"},   aux_o,      model_act[3]);
  endtask

  task automatic wait_bresp();
    bit hs;
    int n;
    S_AXI_BREADY = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK); hs = S_AXI_BVALID;
      tick(); n++;
    end while (!hs && n < 50);
    check_bound("b_handshake", hs);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bq.push_back(2'b00);
    model_sh[a[3:2]] = byte_merge(model_sh[a[3:2]], d, s);
    fork
      begin
        bit hs;
        int n;
        repeat (aw_dly) tick();
        S_AXI_AWADDR  = a;
        S_AXI_AWPROT  = 3'($urandom_range(0, 7));
        S_AXI_AWVALID = 1'b1;
        n = 0;
        do begin
          @(negedge ACLK); hs = S_AXI_AWREADY;
          tick(); n++;
        end while (!hs && n < 50);
        check_bound("aw_handshake", hs);
        S_AXI_AWVALID = 1'b0;
      end
      begin
        bit hs;
        int n;
        repeat (w_dly) tick();
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        S_AXI_WVALID = 1'b1;
        n = 0;
        do begin
          @(negedge ACLK); hs = S_AXI_WREADY;
          tick(); n++;
        end while (!hs && n < 50);
        check_bound("w_handshake", hs);
        S_AXI_WVALID = 1'b0;
      end
    join
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_hold", S_AXI_BVALID, 1);
    end
    wait_bresp();
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_dly);
    bit hs;
    int n;
    rq.push_back(model_sh[a[3:2]]);
    S_AXI_ARADDR  = a;
    S_AXI_ARPROT  = 3'($urandom_range(0, 7));
    S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK); hs = S_AXI_ARREADY;
      tick(); n++;
    end while (!hs && n < 50);
    check_bound("ar_handshake", hs);
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < r_dly; i++) begin
      check("rvalid_hold", S_AXI_RVALID, 1);
      tick();
    end
    S_AXI_RREADY = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK); hs = S_AXI_RVALID;
      tick(); n++;
    end while (!hs && n < 50);
    check_bound("r_handshake", hs);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic vsync_pulse();
    vsync_i = 1'b1;
    tick();
    vsync_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) model_act[i] = model_sh[i];
  endtask

  // Monitor: compare every completed read and write response against the scoreboard
  initial begin
    logic [31:0] exp_d;
    logic [1:0]  exp_b;
    forever begin
      @(negedge ACLK);
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) begin
          tests++; errors++;
          $display("FAIL unexpected_read: got rdata %h expected no response", S_AXI_RDATA);
        end else begin
          exp_d = rq.pop_front();
          check("rdata", S_AXI_RDATA, exp_d);
          check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        end
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) begin
          tests++; errors++;
          $display("FAIL unexpected_bresp: got bvalid 1 expected no response");
        end else begin
          exp_b = bq.pop_front();
          check("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_b});
        end
      end
    end
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] old_sh [4];

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    vsync_i = 1'b0;
    for (int i = 0; i < 4; i++) begin model_sh[i] = '0; model_act[i] = '0; end

    // Reset state
    repeat (3) tick();
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_wready",  S_AXI_WREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid",  S_AXI_BVALID, 0);
    check("rst_rvalid",  S_AXI_RVALID, 0);
    check("rst_rdata",   S_AXI_RDATA, 0);
    check_active("rst");
    ARESET = 1'b0;
    @(negedge ACLK);
    check("ready_before_edge", S_AXI_AWREADY, 0);
    tick();
    check("awready_after_rst", S_AXI_AWREADY, 1);
    check("wready_after_rst",  S_AXI_WREADY, 1);
    check("arready_after_rst", S_AXI_ARREADY, 1);

    // Basic write then read of every register
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // W leads AW by three cycles, BREADY withheld for five
    axi_write(4'hC, 32'h5A5A_0031, 4'hF, 3, 0, 5);
    axi_read(4'hC, 2);

    // Byte-strobe merge
    axi_write(4'h4, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h1122_3344, 4'b0101, 1, 2, 1);
    axi_read(4'h4, 0);

    // Randomized traffic; CTRL IMMEDIATE kept clear so active copies stay at zero
    for (int i = 0; i < 30; i++) begin
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if (a[3:2] == 2'd0) d[1] = 1'b0;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end

    // Concurrent read and write on different registers
    fork
      axi_write(4'h8, 32'h0000_1000, 4'hF, 0, 1, 2);
      axi_read(4'h5, 1);
    join

    // Active copies hold until vsync
    check("fb_before_vsync", fb_base_o, 32'h0);
    check_active("no_vsync");
    vsync_pulse();
    check("fb_after_vsync", fb_base_o, 32'h0000_1000);
    check_active("vsync");

    // Immediate mode: outputs track shadow
    axi_write(4'h0, 32'h0000_0002, 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) model_act[i] = model_sh[i];
    check_active("imm_on");
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if (a[3:2] == 2'd0) d[1] = 1'b1;
      axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), 0);
      for (int k = 0; k < 4; k++) model_act[k] = model_sh[k];
      check_active("imm_track");
    end

    // Leaving immediate mode freezes the pre-write values
    for (int i = 0; i < 4; i++) model_act[i] = model_sh[i];
    axi_write(4'h0, 32'h0000_0000, 4'hF, 0, 0, 0);
    repeat (2) tick();
    check_active("imm_off");
    axi_write(4'h4, $urandom, 4'hF, 0, 0, 0);
    check_active("frozen");

    // Write commit coinciding with a vsync edge: active takes the pre-write value
    for (int i = 0; i < 4; i++) old_sh[i] = model_sh[i];
    check("awready_idle", S_AXI_AWREADY, 1);
    check("wready_idle", S_AXI_WREADY, 1);
    d = $urandom;
    bq.push_back(2'b00);
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    vsync_i = 1'b1;
    tick();
    vsync_i = 1'b0;
    for (int i = 0; i < 4; i++) model_act[i] = old_sh[i];
    model_sh[3] = d;
    check_active("same_cycle");
    wait_bresp();
    tick();
    check_active("same_cycle_hold");
    vsync_pulse();
    check_active("next_vsync");
    axi_read(4'hC, 0);

    // Reset between AW and W: transaction is dropped
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    tick();
    ARESET = 1'b1;
    for (int i = 0; i < 4; i++) begin model_sh[i] = '0; model_act[i] = '0; end
    @(negedge ACLK);
    check("midrst_awready", S_AXI_AWREADY, 0);
    check("midrst_bvalid", S_AXI_BVALID, 0);
    check_active("midrst");
    tick();
    ARESET = 1'b0;
    S_AXI_BREADY = 1'b1;
    repeat (4) tick();
    check("no_bresp_after_rst", S_AXI_BVALID, 0);
    S_AXI_BREADY = 1'b0;
    axi_read(4'h4, 0);
    axi_write(4'h4, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    axi_read(4'h4, 0);
    vsync_pulse();
    check_active("post_rst_vsync");

    repeat (3) tick();
    check("rq_drained", 32'(rq.size()), 0);
    check("bq_drained", 32'(bq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
